pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: FETCH_TIMEOUT, default 15, max FETCH-state cycles waiting imem_ack before error (range 1..255).
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: start  in  1  level; leaves IDLE and begins fetching.
REQ-005 Port: imem_req  out  1  instruction fetch request to instruction memory.
REQ-006 Port: imem_ack  in  1  fetch data valid this cycle.
REQ-007 Port: redir_valid  in  1  decode result valid; qualifies redir_kind and br_taken.
REQ-008 Port: redir_kind  in  2  00 sequential, 01 jump, 10 register jump, 11 conditional branch.
REQ-009 Port: br_taken  in  1  branch condition result; used only when redir_kind=11.
REQ-010 Port: stall  in  1  holds the sequencer in EXEC.
REQ-011 Port: halt  in  1  stop request; enters HALT at the next UPDATE.
REQ-012 Port: pc_en  out  1  one-cycle enable pulse to the program counter register.
REQ-013 Port: pc_ctrl  out  3  next-PC select to the program counter: 000 +4, 001 jump, 010 register, 011 branch.
REQ-014 Port: instr_valid  out  1  one-cycle pulse; fetched instruction may be latched.
REQ-015 Port: fetch_err  out  1  sticky; fetch timeout occurred.
REQ-016 Port: state_o  out  3  current state encoding, for debug.

Function
REQ-017 States, with state_o encodings: IDLE=0, FETCH=1, EXEC=2, UPDATE=3, HALT=4, ERR=5; all other encodings go to IDLE on the next cycle.
REQ-018 IDLE: start=1 -> FETCH; otherwise stay in IDLE.
REQ-019 FETCH: imem_req=1 combinationally.
REQ-020 FETCH: imem_ack=1 -> EXEC, instr_valid pulses in that same cycle, wait counter cleared.
REQ-021 FETCH: each cycle without imem_ack increments an 8-bit wait counter.
REQ-022 FETCH: if the counter reaches FETCH_TIMEOUT without imem_ack -> ERR; imem_ack arriving in the reaching cycle takes priority (-> EXEC).
REQ-023 EXEC: pending-redirect register latched when redir_valid=1 and stall=0.
REQ-024 Pending-redirect mapping: kind 00 -> 000; 01 -> 001; 10 -> 010; 11 with br_taken=1 -> 011; 11 with br_taken=0 -> 000.
REQ-025 EXEC: leaves to UPDATE in the cycle after the redirect is latched.
REQ-026 EXEC: stall=1 holds EXEC with no latch, regardless of redir_valid.
REQ-027 EXEC: redir_valid=0 with stall=0 stays in EXEC (no timeout).
REQ-028 UPDATE: pc_en=1 for exactly one cycle, pc_ctrl=pending value; pc_ctrl=000 in every other state.
REQ-029 UPDATE: next state is HALT if halt=1 in that cycle or halt was seen in EXEC; otherwise FETCH.
REQ-030 halt observed during EXEC is recorded in a sticky halt flag, cleared on HALT entry.
REQ-031 Latency: no-wait fetch to PC update is 3 cycles (FETCH, EXEC with redir_valid, UPDATE); total PC-to-PC period 3 cycles minimum.
REQ-032 HALT: stays until start=1, then -> FETCH; pc_en=0, imem_req=0.
REQ-033 ERR: fetch_err=1, imem_req=0, pc_en=0; exits only via rst.
REQ-034 imem_req, pc_en and instr_valid are never high simultaneously.
REQ-035 Exactly one pc_en pulse per instr_valid pulse, except when rst intervenes.

Reset
REQ-036 rst=1 at any clock edge: state=IDLE, wait counter=0, pending=000, halt flag=0, fetch_err=0.
REQ-037 During rst: all outputs low, state_o=0.
REQ-038 rst overrides start, imem_ack and halt in the same cycle.
REQ-039 rst mid-FETCH or mid-UPDATE: no pc_en pulse is issued after the reset edge.

Verification
REQ-040 Reset, start=1, imem_ack on first FETCH cycle, redir_kind=00 on first EXEC cycle -> pc_en in cycle 3 with pc_ctrl=000; repeats every 3 cycles.
REQ-041 redir_kind=11, br_taken=0 then 11/1 then 01 then 10 -> successive UPDATE pc_ctrl = 000, 011, 001, 010.
REQ-042 FETCH_TIMEOUT=4, no imem_ack -> ERR entered after 4 FETCH cycles, fetch_err=1 sticky, no pc_en until rst.
REQ-043 stall=1 for 5 cycles while redir_valid=1 -> EXEC held 5 cycles, no pc_en; redirect latched on the first stall=0 cycle.
REQ-044 halt pulsed during EXEC -> single pc_en, then HALT with imem_req=0; start=1 -> FETCH next cycle.
REQ-045 rst asserted in UPDATE cycle -> pc_en=0 that cycle, state_o=0 next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Instruction sequencer: walks FETCH -> EXEC -> UPDATE and drives the PC select.
// A fetch that waits too long for imem_ack parks the block in ERR until reset.
module pc_sequencer #(
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       imem_req,
  input  logic       imem_ack,
  input  logic       redir_valid,
  input  logic [1:0] redir_kind,
  input  logic       br_taken,
  input  logic       stall,
  input  logic       halt,
  output logic       pc_en,
  output logic [2:0] pc_ctrl,
  output logic       instr_valid,
  output logic       fetch_err,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(FETCH_TIMEOUT);

  state_t     state, state_n;
  logic [7:0] wait_cnt, wait_n;
  logic [2:0] pend, pend_n;
  logic       halt_flag, halt_flag_n;
  logic       err, err_n;
  logic [2:0] redir_sel;

  always_comb begin
    redir_sel = 3'b000;
    case (redir_kind)
      2'b00: redir_sel = 3'b000;
      2'b01: redir_sel = 3'b001;
      2'b10: redir_sel = 3'b010;
      2'b11: redir_sel = br_taken ? 3'b011 : 3'b000;
      default: redir_sel = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 8'd0;
      pend      <= 3'b000;
      halt_flag <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_n;
      pend      <= pend_n;
      halt_flag <= halt_flag_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    pend_n      = pend;
    halt_flag_n = halt_flag;
    err_n       = err;
    imem_req    = 1'b0;
    pc_en       = 1'b0;
    pc_ctrl     = 3'b000;
    instr_valid = 1'b0;
    case (state)
      S_IDLE: begin
        wait_n = 8'd0;
        if (start) state_n = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // ack in the cycle the count would expire still wins over the timeout
        if (imem_ack) begin
          instr_valid = 1'b1;
          wait_n      = 8'd0;
          state_n     = S_EXEC;
        end else if (wait_cnt + 8'd1 >= TIMEOUT) begin
          wait_n  = 8'd0;
          err_n   = 1'b1;
          state_n = S_ERR;
        end else begin
          wait_n = wait_cnt + 8'd1;
        end
      end
      S_EXEC: begin
        if (halt) halt_flag_n = 1'b1;
        if (!stall && redir_valid) begin
          pend_n  = redir_sel;
          state_n = S_UPDATE;
        end
      end
      S_UPDATE: begin
        pc_en   = 1'b1;
        pc_ctrl = pend;
        if (halt || halt_flag) begin
          halt_flag_n = 1'b0;
          state_n     = S_HALT;
        end else begin
          state_n = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) state_n = S_FETCH;
      end
      S_ERR: ;
      default: state_n = S_IDLE;
    endcase
    // reset silences outputs in the same cycle, so an UPDATE hit by rst never pulses pc_en
    if (rst) begin
      imem_req    = 1'b0;
      pc_en       = 1'b0;
      pc_ctrl     = 3'b000;
      instr_valid = 1'b0;
    end
  end

  assign fetch_err = err & ~rst;
  assign state_o   = rst ? 3'd0 : state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a spec-level model checked every cycle,
// plus literal expectations on pulse timing, PC selects, timeout and halt.
module tb_pc_sequencer;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst, start, imem_ack, redir_valid, br_taken, stall, halt;
  logic [1:0] redir_kind;
  logic       imem_req, pc_en, instr_valid, fetch_err;
  logic [2:0] pc_ctrl, state_o;

  pc_sequencer #(.FETCH_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_req(imem_req), .imem_ack(imem_ack),
    .redir_valid(redir_valid), .redir_kind(redir_kind), .br_taken(br_taken),
    .stall(stall), .halt(halt), .pc_en(pc_en), .pc_ctrl(pc_ctrl),
    .instr_valid(instr_valid), .fetch_err(fetch_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int en_cnt = 0, iv_cnt = 0;
  int en_cyc[$];
  int en_ctrl[$];

  // model: phase is the spec's state number; fetches counts FETCH cycles without ack
  int phase = 0, fetches = 0, pend_sel = 0;
  bit halt_seen = 0, err_seen = 0;

  logic       s_req, s_en, s_iv, s_err;
  logic [2:0] s_ctrl, s_state;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int redirect_of(input int kind, input bit taken);
    if (kind == 0) return 0;
    if (kind == 1) return 1;
    if (kind == 2) return 2;
    return taken ? 3 : 0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      phase = 0; fetches = 0; pend_sel = 0; halt_seen = 0; err_seen = 0;
    end else begin
      case (phase)
        0, 4: if (start) begin phase = 1; fetches = 0; end
        1: begin
          if (imem_ack) phase = 2;
          else begin
            fetches++;
            if (fetches == TO) begin phase = 5; err_seen = 1; end
          end
        end
        2: begin
          if (halt) halt_seen = 1;
          if (!stall && redir_valid) begin
            pend_sel = redirect_of(int'(redir_kind), br_taken);
            phase = 3;
          end
        end
        3: begin
          fetches = 0;
          if (halt || halt_seen) begin phase = 4; halt_seen = 0; end
          else phase = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare();
    logic [9:0] got, want;
    s_req = imem_req; s_en = pc_en; s_ctrl = pc_ctrl;
    s_iv = instr_valid; s_err = fetch_err; s_state = state_o;
    got = {s_req, s_en, s_ctrl, s_iv, s_err, s_state};
    if (rst) want = 10'd0;
    else want = {phase == 1, phase == 3, (phase == 3) ? 3'(pend_sel) : 3'd0,
                 (phase == 1) && imem_ack, err_seen, 3'(phase)};
    chk("outputs", int'(got), int'(want));
    if (s_en) begin en_cnt++; en_cyc.push_back(cyc); en_ctrl.push_back(int'(s_ctrl)); end
    if (s_iv) iv_cnt++;
  endtask

  task automatic step();
    #3;
    compare();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic drive(input logic s, input logic a, input logic rv, input logic [1:0] k,
                       input logic bt, input logic sl, input logic h);
    start = s; imem_ack = a; redir_valid = rv; redir_kind = k;
    br_taken = bt; stall = sl; halt = h;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 2'd0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
  endtask

  int c0, e0;
  int kinds[4] = '{3, 3, 1, 2};
  int takens[4] = '{0, 1, 0, 0};
  int ctrls[4] = '{0, 3, 1, 2};

  initial begin
    // reset and steady 3-cycle PC period with sequential redirects
    do_reset();
    chk("reset_state", int'(s_state), 0);
    chk("reset_err", int'(s_err), 0);
    en_cyc.delete(); en_ctrl.delete();
    drive(1, 1, 1, 2'd0, 0, 0, 0);
    c0 = cyc;
    repeat (10) step();
    chk("seq_pulses", en_cyc.size(), 3);
    if (en_cyc.size() >= 3) begin
      chk("seq_first_lat", en_cyc[0] - c0, 3);
      chk("seq_period1", en_cyc[1] - en_cyc[0], 3);
      chk("seq_period2", en_cyc[2] - en_cyc[1], 3);
      chk("seq_ctrl", en_ctrl[2], 0);
    end

    // redirect kinds in turn
    do_reset();
    en_ctrl.delete();
    drive(1, 1, 1, 2'd0, 0, 0, 0);
    step();
    for (int p = 0; p < 4; p++) begin
      drive(1, 1, 1, 2'(kinds[p]), 1'(takens[p]), 0, 0);
      repeat (3) step();
    end
    chk("redir_count", en_ctrl.size(), 4);
    if (en_ctrl.size() >= 4)
      for (int i = 0; i < 4; i++) chk("redir_ctrl", en_ctrl[i], ctrls[i]);

    // fetch timeout
    do_reset();
    e0 = en_cnt;
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    step();
    repeat (4) step();
    chk("to_last_fetch", int'(s_state), 1);
    step();
    chk("to_err_state", int'(s_state), 5);
    chk("to_err_flag", int'(s_err), 1);
    chk("to_err_req", int'(s_req), 0);
    drive(1, 1, 1, 2'd0, 0, 0, 0);
    repeat (5) step();
    chk("to_sticky", int'(s_err), 1);
    chk("to_stuck", int'(s_state), 5);
    chk("to_no_pc_en", en_cnt - e0, 0);

    // stall holds EXEC
    do_reset();
    e0 = en_cnt;
    drive(1, 1, 0, 2'd0, 0, 0, 0);
    step(); step();
    drive(0, 0, 1, 2'd1, 0, 1, 0);
    repeat (5) step();
    chk("stall_hold", int'(s_state), 2);
    chk("stall_no_en", en_cnt - e0, 0);
    drive(0, 0, 1, 2'd1, 0, 0, 0);
    step();
    step();
    chk("stall_update_en", int'(s_en), 1);
    chk("stall_update_ctrl", int'(s_ctrl), 1);

    // halt during EXEC
    do_reset();
    e0 = en_cnt;
    drive(1, 1, 0, 2'd0, 0, 0, 0);
    step(); step();
    drive(0, 0, 0, 2'd0, 0, 0, 0);
    step();
    chk("exec_wait", int'(s_state), 2);
    drive(0, 0, 0, 2'd0, 0, 0, 1);
    step();
    drive(0, 0, 1, 2'd2, 0, 0, 0);
    step(); step();
    chk("halt_update_ctrl", int'(s_ctrl), 2);
    step();
    chk("halt_state", int'(s_state), 4);
    chk("halt_req", int'(s_req), 0);
    repeat (3) step();
    chk("halt_stays", int'(s_state), 4);
    chk("halt_one_en", en_cnt - e0, 1);
    drive(1, 0, 0, 2'd0, 0, 0, 0);
    step(); step();
    chk("halt_restart", int'(s_state), 1);

    // reset landing on UPDATE
    do_reset();
    e0 = en_cnt;
    drive(1, 1, 1, 2'd0, 0, 0, 0);
    step(); step(); step();
    rst = 1'b1;
    step();
    chk("rst_upd_en", int'(s_en), 0);
    rst = 1'b0;
    step();
    chk("rst_upd_state", int'(s_state), 0);
    chk("rst_upd_no_en", en_cnt - e0, 0);
    chk("iv_vs_en", iv_cnt - en_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
